// File: rtl/sum_bist.sv
// Built-in self-test engine for a 4-bit ripple adder: drives all 256 operand
// pairs, compares each settled result with a+b, and reports errors and the first bad vector.
module sum_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  input  logic       o0,
  input  logic       o1,
  input  logic       o2,
  input  logic       o3,
  input  logic       o4,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [3:0] fail_a,
  output logic [3:0] fail_b,
  output logic       fail_valid
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [3:0] settle_q, settle_d;
  logic [8:0] err_q, err_d;
  logic [3:0] fa_q, fa_d;
  logic [3:0] fb_q, fb_d;
  logic       fv_q, fv_d;
  logic       pass_q, pass_d;

  logic [3:0] op_a, op_b;
  logic [4:0] result, golden;
  logic       mismatch;

  assign op_a   = vec_q[7:4];
  assign op_b   = vec_q[3:0];
  assign result = {o4, o3, o2, o1, o0};
  assign golden = {1'b0, op_a} + {1'b0, op_b};

  // Written as if/else so an unknown result falls into the mismatch branch.
  always_comb begin
    if (result == golden) mismatch = 1'b0;
    else                  mismatch = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    fv_d     = fv_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d    = 8'd0;
          settle_d = SETTLE_INIT;
          err_d    = 9'd0;
          fa_d     = 4'd0;
          fb_d     = 4'd0;
          fv_d     = 1'b0;
          pass_d   = 1'b0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_q <= 4'd1) state_d  = S_CHECK;
        else                  settle_d = settle_q - 4'd1;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 9'd1;
          if (!fv_q) begin
            fa_d = op_a;
            fb_d = op_b;
            fv_d = 1'b1;
          end
        end
        if (vec_q == 8'hFF) begin
          pass_d  = (err_d == 9'd0);
          state_d = S_DONE;
        end else begin
          vec_d    = vec_q + 8'd1;
          settle_d = SETTLE_INIT;
          state_d  = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= 8'd0;
      settle_q <= 4'd0;
      err_q    <= 9'd0;
      fa_q     <= 4'd0;
      fb_q     <= 4'd0;
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      fv_q     <= fv_d;
      pass_q   <= pass_d;
    end
  end

  assign {x3, x2, x1, x0} = op_a;
  assign {y3, y2, y1, y0} = op_b;
  assign busy       = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_sum_bist.sv
// Bench for sum_bist: a configurable faulty adder feeds the engine; results are
// compared with constant tables and a counting model over a random fault map.
module tb_sum_bist;

  logic clk = 1'b0;
  logic rst, start, start3;
  logic x0, x1, x2, x3, y0, y1, y2, y3;
  logic o0, o1, o2, o3, o4;
  logic busy, done, pass, fail_valid;
  logic [8:0] err_count;
  logic [3:0] fail_a, fail_b;

  logic x30, x31, x32, x33, y30, y31, y32, y33;
  logic busy3, done3, pass3, fail_valid3;
  logic [8:0] err_count3;
  logic [3:0] fail_a3, fail_b3;
  logic [4:0] sum3;

  int   mode;
  logic bad [256];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sum_bist #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_valid(fail_valid)
  );

  sum_bist #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .x0(x30), .x1(x31), .x2(x32), .x3(x33), .y0(y30), .y1(y31), .y2(y32), .y3(y33),
    .o0(sum3[0]), .o1(sum3[1]), .o2(sum3[2]), .o3(sum3[3]), .o4(sum3[4]),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
    .fail_a(fail_a3), .fail_b(fail_b3), .fail_valid(fail_valid3)
  );

  assign sum3 = {1'b0, x33, x32, x31, x30} + {1'b0, y33, y32, y31, y30};

  // Adder under test: 0 golden, 1 carry stuck 0, 2 o0 inverted, 3 o3 stuck 1, 4 random map
  always_comb begin
    logic [3:0] a, b;
    logic [4:0] s;
    a = {x3, x2, x1, x0};
    b = {y3, y2, y1, y0};
    s = {1'b0, a} + {1'b0, b};
    case (mode)
      1:       s[4] = 1'b0;
      2:       s[0] = ~s[0];
      3:       s[3] = 1'b1;
      4:       if (bad[{a, b}]) s = s ^ 5'h01;
      default: ;
    endcase
    {o4, o3, o2, o1, o0} = s;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Starts a run on the SETTLE=1 engine; returns edges from the start edge to done.
  task automatic run1(input int pulse_at, input int rst_at, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("err_cleared", err_count, 0);
    check("fv_cleared", fail_valid, 0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (cyc == pulse_at) start = 1'b1;
      if (cyc == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc == rst_at + 1) begin
        rst = 1'b0;
        return;
      end
    end
  endtask

  typedef struct {
    int   md;
    int   exp_err;
    logic exp_fv;
    int   exp_fa;
    int   exp_fb;
    logic exp_pass;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc, n_bad, first, bad_win;
    tbl[0] = '{0, 0,   1'b0, 0, 0,  1'b1};
    tbl[1] = '{1, 120, 1'b1, 1, 15, 1'b0};
    tbl[2] = '{2, 256, 1'b1, 0, 0,  1'b0};
    tbl[3] = '{3, 128, 1'b1, 0, 0,  1'b0};
    foreach (bad[i]) bad[i] = 1'b0;
    mode = 0; start = 0; start3 = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fv", fail_valid, 0);
    check("rst_xy", {x3, x2, x1, x0, y3, y2, y1, y0}, 0);
    rst = 0;

    for (int t = 0; t < 4; t++) begin
      mode = tbl[t].md;
      run1(-1, -1, cyc);
      check("done_latency", cyc, 512);
      check("err_count", err_count, tbl[t].exp_err);
      check("fail_valid", fail_valid, tbl[t].exp_fv);
      if (tbl[t].exp_fv) begin
        check("fail_a", fail_a, tbl[t].exp_fa);
        check("fail_b", fail_b, tbl[t].exp_fb);
      end
      check("pass", pass, tbl[t].exp_pass);
      repeat (3) @(posedge clk);
      #1 check("done_held", done, 1);
    end

    // Restart from DONE (previous run left err_count=128) must match a fresh run.
    mode = 1;
    run1(-1, -1, cyc);
    check("rerun_latency", cyc, 512);
    check("rerun_err", err_count, 120);
    check("rerun_fa", fail_a, 1);
    check("rerun_fb", fail_b, 15);

    // Random fault maps against a counting model.
    for (int r = 0; r < 3; r++) begin
      n_bad = 0; first = -1;
      for (int i = 0; i < 256; i++) begin
        bad[i] = ($urandom_range(0, 15) == 0);
        if (bad[i]) begin
          n_bad++;
          if (first < 0) first = i;
        end
      end
      mode = 4;
      run1(-1, -1, cyc);
      check("rnd_latency", cyc, 512);
      check("rnd_err", err_count, n_bad);
      check("rnd_fv", fail_valid, n_bad != 0);
      if (first >= 0) begin
        check("rnd_fa", fail_a, first / 16);
        check("rnd_fb", fail_b, first % 16);
      end
      check("rnd_pass", pass, n_bad == 0);
    end

    // Start pulse mid-run is ignored.
    mode = 0;
    run1(50, -1, cyc);
    check("midstart_latency", cyc, 512);
    check("midstart_pass", pass, 1);

    // Reset 100 cycles into a faulty run, then a clean run.
    mode = 1;
    run1(-1, 100, cyc);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err_count, 0);
    check("midrst_fv", fail_valid, 0);
    check("midrst_xy", {x3, x2, x1, x0, y3, y2, y1, y0}, 0);
    mode = 0;
    run1(-1, -1, cyc);
    check("postrst_latency", cyc, 512);
    check("postrst_pass", pass, 1);

    // SETTLE_CYCLES=3: operands steady across each 4-cycle window, B fastest.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    check("s3_busy", busy3, 1);
    bad_win = 0;
    for (int k = 0; k < 256; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k != 0 || c != 0) begin
          @(posedge clk); #1;
        end
        if ({x33, x32, x31, x30, y33, y32, y31, y30} !== 8'(k) || done3 !== 1'b0) bad_win++;
      end
    end
    check("s3_windows", bad_win, 0);
    @(posedge clk); #1;
    check("s3_done_1024", done3, 1);
    check("s3_pass", pass3, 1);
    check("s3_err", err_count3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_bist.md
Name: sum_bist

Overview:
- Hardware self-test engine for the 4-bit ripple adder `sum`; it sits on the other side of the adder's pin interface.
- Drives every operand pair onto the adder inputs (x0..x3, y0..y3) and samples the 5-bit result (o0..o3 sum, o4 carry).
- Compares each result against an internal golden a+b and reports pass/fail, error count and first failing vector.
- Replaces the exhaustive simulation stimulus with a synthesizable on-chip checker.

Parameters:
- SETTLE_CYCLES, 1: cycles between applying operands and sampling outputs. Legal range is 1..15; values below 1 are illegal.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a test run; sampled only in IDLE or DONE
- x0,x1,x2,x3  output  1 each  operand A to adder, x0 = LSB
- y0,y1,y2,y3  output  1 each  operand B to adder, y0 = LSB
- o0,o1,o2,o3  input  1 each  adder sum bits, o0 = LSB
- o4  input  1  adder carry-out
- busy  output  1  run in progress
- done  output  1  run complete; held until next start or rst
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  9  number of mismatching vectors, range 0..256
- fail_a  output  4  operand A of the first mismatch
- fail_b  output  4  operand B of the first mismatch
- fail_valid  output  1  fail_a/fail_b hold a captured vector

Behaviour:
- Reset (rst=1 at a clock edge, any state including mid-run):
  - State goes to IDLE.
  - Outputs busy, done, pass, fail_valid, err_count, fail_a, fail_b and all x/y bits go to 0.
  - Internal vector counter and settle counter clear.
- Vector counter: 8-bit `vec`, A = vec[7:4] and B = vec[3:0] (A-major order). Drive x = A, y = B.
- Expected result: 5-bit unsigned {o4,o3,o2,o1,o0} == A + B, zero-extended. No carry-in.
- State machine:
  - IDLE: busy=0, done=0. On start=1: vec<=0, x/y<=0, settle counter<=SETTLE_CYCLES, err_count<=0, fail_valid<=0, pass<=0; go to WAIT with busy=1.
  - WAIT: settle counter decrements each cycle; when it reaches 1, go to CHECK.
  - CHECK: compare the sampled result with A+B.
    - On mismatch: err_count<=err_count+1. If fail_valid=0, capture fail_a=A, fail_b=B and set fail_valid=1.
    - If vec==255: go to DONE.
    - Otherwise: vec<=vec+1, drive the new operands in the same edge, reload the settle counter, return to WAIT.
  - DONE: busy=0, done=1, pass=(err_count==0). Final err_count and fail_* are held. start=1 restarts exactly as from IDLE and clears done the next cycle.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done rises (SETTLE_CYCLES+1)*256 cycles after the edge that samples start (512 cycles for the default).
  - Operands are stable for the whole WAIT+CHECK window of their vector.
- Boundary conditions:
  - vec wrap 255->0 never occurs; the run ends at 255.
  - err_count reaches at most 256 and never overflows 9 bits.
  - start while busy=1 is ignored; the run continues unaffected.
  - start held high through DONE retriggers exactly once per DONE entry, then is ignored while busy.
  - X/Z on o* counts as a mismatch.

Test Plan:
- Golden adder attached, SETTLE_CYCLES=1, start pulse -> busy=1 next cycle; done=1 exactly 512 cycles after start edge; pass=1, err_count=0, fail_valid=0.
- Carry o4 tied 0 -> done; err_count=120 (pairs with A+B>=16); fail_valid=1; fail_a=1, fail_b=15; pass=0.
- Sum bit o0 inverted -> err_count=256; fail_a=0, fail_b=0; pass=0.
- SETTLE_CYCLES=3 with golden adder -> done at 1024 cycles. Bench checks x/y constant across each 4-cycle window and stepping B fastest (A=0,B=0..15, then A=1...).
- rst asserted for one cycle 100 cycles into a run -> next cycle busy=0, done=0, err_count=0, x/y=0, state IDLE. A new start completes normally in 512 cycles.
- start pulsed at cycle 50 of a run -> no effect (done still at cycle 512). start in DONE -> done=0 next cycle, counters cleared, second run completes with identical results.
